match_controller: RTL
=====================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter HEALTH_MAX, 8'd100: health loaded per player at round start.
REQ-002 Parameter DMG, 8'd10: health removed per registered hit.
REQ-003 Parameter ROUND_TICKS, 16'd3600: frame ticks per round.
REQ-004 Parameter INTRO_TICKS, 16'd120: frame ticks spent in INTRO.
REQ-005 Parameter WINS_NEEDED, 4'd2: round wins that end the match.
REQ-006 effective_clk  in  1  system clock. reset  in  1  reset, asynchronous, active-high.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 start_pvp, start_pvai  in  1 each  match start requests, level-sampled.
REQ-009 hit_p1, hit_p2  in  1 each  pulse: player 1 / player 2 landed a hit on the opponent.
REQ-010 ack  in  1  leave GAME_OVER. abort  in  1  return to IDLE from any state.
REQ-011 state  out  3  current state code. ai_sel  out  1  player 2 driven by the random source.
REQ-012 round_rst  out  1  one-cycle pulse that resets both player blocks.
REQ-013 health1, health2  out  8  live health. wins1, wins2  out  4  rounds won.
REQ-014 round_timer  out  16  remaining round ticks. winner  out  2  0 none, 1 P1, 2 P2, 3 draw.

Function
REQ-015 States: IDLE=0, INTRO=1, PVP=2, PVAI=3, GAME_OVER=4; every output is registered and every transition takes effect on the clock edge after its condition is sampled.
REQ-016 IDLE: start_pvp -> INTRO with mode latched to PvP; otherwise start_pvai -> INTRO with mode latched to PvAI; start_pvp takes priority when both are high; wins1/wins2 are cleared on leaving IDLE.
REQ-017 INTRO: the intro counter loads INTRO_TICKS on entry and decrements on frame_tick; at zero -> the latched mode state.
REQ-018 On the INTRO exit edge: round_rst =1 for exactly one cycle, health1/health2 load HEALTH_MAX, round_timer loads ROUND_TICKS, winner clears to 0.
REQ-019 PVP/PVAI: round_timer decrements by 1 per frame_tick and holds at 0 (no wrap).
REQ-020 hit_p1 reduces health2 by DMG and hit_p2 reduces health1 by DMG, each saturating at 0; simultaneous hits are both applied in the same cycle.
REQ-021 hit_*, frame_tick, start_* are ignored wherever they have no defined effect, e.g. hits outside PVP/PVAI and starts outside IDLE.
REQ-022 Round end: health1==0 or health2==0 or round_timer==0, evaluated on post-update values.
REQ-023 At round end: the higher health wins and that player's wins counter increments (saturating at 15); equal health (including double KO) sets winner=3 and awards no win.
REQ-024 After round end: if the incremented wins value equals WINS_NEEDED -> GAME_OVER with winner set; otherwise -> INTRO.
REQ-025 GAME_OVER: all outputs hold; ack -> IDLE.
REQ-026 abort -> IDLE from any state; abort takes priority over every other transition.
REQ-027 ai_sel =1 only while state==PVAI.

Reset
REQ-028 Reset forces state=IDLE, latched mode=PvP, health=HEALTH_MAX, round_timer=ROUND_TICKS, wins=0, winner=0, round_rst=0, ai_sel=0.
REQ-029 Reset asserted mid-round discards the round with no score update, and no round_rst pulse is produced while reset is active.

Structure
REQ-030 The shared package game_pkg holds the state codes, the winner codes, and the HEALTH_W=8, TIMER_W=16, WINS_W=4 width constants.
REQ-031 Sub-module tick_counter implements a loadable, frame_tick-enabled, zero-saturating down counter with a zero flag; it is instantiated twice, once for the intro timer and once for the round timer.
REQ-032 The random-input mux for player 2 is not part of this block; it consumes ai_sel.

Verification
REQ-033 Bench scenario: start_pvp=start_pvai=1 in IDLE -> INTRO, then PVP after 120 frame_ticks; round_rst is a single-cycle pulse; ai_sel=0.
REQ-034 Bench scenario: PvAI with 10 hit_p1 pulses -> health2 reaches 0, wins1=1, state INTRO; 10 further hits next round -> GAME_OVER, winner=1.
REQ-035 Bench scenario: health2=5 with hit_p1 -> health2=0, no underflow; hit_p1 and hit_p2 in the same cycle at health 10/10 -> both 0, winner=3, no win awarded.
REQ-036 Bench scenario: timer expiry with health 80/60 -> wins1 increments; round_timer holds 0 for the round-end cycle.
REQ-037 Bench scenario: abort during PVP -> IDLE next edge; reset mid-round -> IDLE, wins=0, health=100.
REQ-038 Bench scenario: in GAME_OVER, hit_*/frame_tick -> outputs unchanged; ack -> IDLE; a new start clears wins.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state/winner codes, widths and health arithmetic for the match controller
package game_pkg;
  localparam int HEALTH_W = 8;
  localparam int TIMER_W = 16;
  localparam int WINS_W = 4;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INTRO     = 3'd1,
    S_PVP       = 3'd2,
    S_PVAI      = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_P1   = 2'd1,
    W_P2   = 2'd2,
    W_DRAW = 2'd3
  } winner_t;
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a, input logic [HEALTH_W-1:0] b);
    return a > b ? a - b : '0;
  endfunction
endpackage

// File: rtl/tick_counter.sv
// tick_counter: loadable frame-tick-enabled down counter that saturates at zero
module tick_counter #(
  parameter int W = 16,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         effective_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  // load wins over counting; counting stops at zero instead of wrapping
  always_ff @(posedge effective_clk or posedge reset)
    if (reset) count <= RESET_VAL;
    else if (load) count <= load_val;
    else if (en && !zero) count <= count - W'(1);
endmodule

// File: rtl/match_controller.sv
// match_controller: round/match sequencing, health, timers and scoring for a two-player fight
module match_controller
  import game_pkg::*;
#(
  parameter logic [HEALTH_W-1:0] HEALTH_MAX  = 8'd100,
  parameter logic [HEALTH_W-1:0] DMG         = 8'd10,
  parameter logic [TIMER_W-1:0]  ROUND_TICKS = 16'd3600,
  parameter logic [TIMER_W-1:0]  INTRO_TICKS = 16'd120,
  parameter logic [WINS_W-1:0]   WINS_NEEDED = 4'd2
) (
  input  logic                effective_clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                start_pvp,
  input  logic                start_pvai,
  input  logic                hit_p1,
  input  logic                hit_p2,
  input  logic                ack,
  input  logic                abort,
  output logic [2:0]          state,
  output logic                ai_sel,
  output logic                round_rst,
  output logic [HEALTH_W-1:0] health1,
  output logic [HEALTH_W-1:0] health2,
  output logic [WINS_W-1:0]   wins1,
  output logic [WINS_W-1:0]   wins2,
  output logic [TIMER_W-1:0]  round_timer,
  output logic [1:0]          winner
);
  state_t st, nst;
  logic mode_ai, play, start_req, intro_exit, round_end, round_zero, round_zero_next;
  logic intro_zero, p1_win, p2_win, game_done;
  logic [TIMER_W-1:0] unused_intro_count;
  logic [HEALTH_W-1:0] h1_n, h2_n;
  logic [WINS_W-1:0] w1_inc, w2_inc;
  assign state = st;
  assign play = (st == S_PVP || st == S_PVAI) && !abort;
  assign start_req = st == S_IDLE && (start_pvp || start_pvai) && !abort;
  assign intro_exit = st == S_INTRO && intro_zero && !abort;
  assign h1_n = play && hit_p2 ? sat_sub(health1, DMG) : health1;
  assign h2_n = play && hit_p1 ? sat_sub(health2, DMG) : health2;
  assign round_zero_next = round_zero || (play && frame_tick && round_timer == TIMER_W'(1));
  assign round_end = play && (h1_n == '0 || h2_n == '0 || round_zero_next);
  assign p1_win = h1_n > h2_n;
  assign p2_win = h2_n > h1_n;
  assign w1_inc = wins1 + WINS_W'(wins1 != '1);
  assign w2_inc = wins2 + WINS_W'(wins2 != '1);
  assign game_done = (p1_win && w1_inc == WINS_NEEDED) || (p2_win && w2_inc == WINS_NEEDED);
  tick_counter #(.W(TIMER_W), .RESET_VAL(INTRO_TICKS)) u_intro (
    .effective_clk(effective_clk),
    .reset(reset),
    .load(start_req || round_end),
    .load_val(INTRO_TICKS),
    .en(st == S_INTRO && frame_tick && !abort),
    .count(unused_intro_count),
    .zero(intro_zero)
  );
  tick_counter #(.W(TIMER_W), .RESET_VAL(ROUND_TICKS)) u_round (
    .effective_clk(effective_clk),
    .reset(reset),
    .load(intro_exit),
    .load_val(ROUND_TICKS),
    .en(play && frame_tick),
    .count(round_timer),
    .zero(round_zero)
  );
  // next state: abort first, then the single transition the current state allows
  always_comb
    nst = abort ? S_IDLE :
          start_req ? S_INTRO :
          intro_exit ? (mode_ai ? S_PVAI : S_PVP) :
          round_end ? (game_done ? S_GAME_OVER : S_INTRO) :
          (st == S_GAME_OVER && ack) ? S_IDLE : st;
  // match FSM with registered scoring, health and strobe outputs
  always_ff @(posedge effective_clk or posedge reset)
    if (reset) begin
      st        <= S_IDLE;
      mode_ai   <= 1'b0;
      ai_sel    <= 1'b0;
      round_rst <= 1'b0;
      health1   <= HEALTH_MAX;
      health2   <= HEALTH_MAX;
      wins1     <= '0;
      wins2     <= '0;
      winner    <= W_NONE;
    end else begin
      st        <= nst;
      ai_sel    <= nst == S_PVAI;
      round_rst <= intro_exit;
      if (start_req) begin
        mode_ai <= !start_pvp;
        wins1   <= '0;
        wins2   <= '0;
      end
      if (intro_exit) begin
        health1 <= HEALTH_MAX;
        health2 <= HEALTH_MAX;
        winner  <= W_NONE;
      end
      if (play) begin
        health1 <= h1_n;
        health2 <= h2_n;
      end
      if (round_end) begin
        winner <= p1_win ? W_P1 : p2_win ? W_P2 : W_DRAW;
        if (p1_win) wins1 <= w1_inc;
        if (p2_win) wins2 <= w2_inc;
      end
    end
endmodule
